// File: rtl/alu_in_cmd_arbiter.sv
// rtl/alu_in_cmd_arbiter.sv - per-channel command FIFOs arbitrated into one registered ALU command stage
// Define ALU_IN_ARB_STATS_EN to add the grant_count port with per-channel saturating grant counters.
module alu_in_cmd_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int OP_WIDTH   = 3,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int ARB_MODE   = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          ch_valid,
  output logic [NUM_CH-1:0]          ch_ready,
  input  logic [NUM_CH*OP_WIDTH-1:0] ch_op,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_a,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_b,
  output logic                       alu_valid,
  input  logic                       alu_ready,
  output logic [OP_WIDTH-1:0]        alu_op,
  output logic [DATA_WIDTH-1:0]      alu_a,
  output logic [DATA_WIDTH-1:0]      alu_b,
  output logic [$clog2(NUM_CH)-1:0]  alu_ch_id,
  output logic [NUM_CH-1:0]          ch_empty
`ifdef ALU_IN_ARB_STATS_EN
  ,output logic [NUM_CH*16-1:0]      grant_count
`endif
);

  localparam int CW   = $clog2(NUM_CH);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;
  localparam int EW   = OP_WIDTH + 2*DATA_WIDTH;

  typedef enum logic {ST_EMPTY, ST_HOLD} state_t;

  logic [EW-1:0]   mem_q    [NUM_CH][FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q [NUM_CH];
  logic [PW-1:0]   rd_ptr_q [NUM_CH];
  logic [CNTW-1:0] count_q  [NUM_CH];

  state_t          state_q;
  logic [EW-1:0]   out_q;
  logic [CW-1:0]   ch_id_q;
  logic [CW-1:0]   rr_ptr_q;
  logic [CW-1:0]   rr_ptr_d;

  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] nonempty;
  logic              any_req;
  logic              load;
  logic [CW-1:0]     gnt_idx;
  logic [EW-1:0]     head_data;

  // ch_ready uses the pre-edge occupancy, so a full FIFO refuses even if it pops this cycle
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign nonempty[g] = (count_q[g] != '0);
    assign ch_empty[g] = ~nonempty[g];
    assign ch_ready[g] = (count_q[g] != CNTW'(FIFO_DEPTH));
    assign push[g]     = ch_valid[g] & ch_ready[g];
    assign pop[g]      = load && (gnt_idx == CW'(g));
  end

  assign any_req = |nonempty;
  assign load    = ((state_q == ST_EMPTY) || alu_ready) && any_req;

  always_comb begin
    logic found;
    int   idx;
    found   = 1'b0;
    idx     = 0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ARB_MODE == 1) begin
        idx = k;
      end else begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= NUM_CH) idx = idx - NUM_CH;
      end
      if (!found && nonempty[idx]) begin
        gnt_idx = CW'(idx);
        found   = 1'b1;
      end
    end
  end

  assign rr_ptr_d  = (gnt_idx == CW'(NUM_CH-1)) ? '0 : gnt_idx + 1'b1;
  assign head_data = mem_q[gnt_idx][rd_ptr_q[gnt_idx]];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (push[i]) begin
        mem_q[i][wr_ptr_q[i]] <= {ch_op[i*OP_WIDTH +: OP_WIDTH],
                                  ch_a[i*DATA_WIDTH +: DATA_WIDTH],
                                  ch_b[i*DATA_WIDTH +: DATA_WIDTH]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
        if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
        if (push[i] && !pop[i])      count_q[i] <= count_q[i] + 1'b1;
        else if (pop[i] && !push[i]) count_q[i] <= count_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_EMPTY;
      out_q    <= '0;
      ch_id_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (load) begin
            out_q   <= head_data;
            ch_id_q <= gnt_idx;
            if (ARB_MODE == 0) rr_ptr_q <= rr_ptr_d;
            state_q <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (load) begin
            out_q   <= head_data;
            ch_id_q <= gnt_idx;
            if (ARB_MODE == 0) rr_ptr_q <= rr_ptr_d;
          end else if (alu_ready) begin
            state_q <= ST_EMPTY;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

  assign alu_valid = (state_q == ST_HOLD);
  assign alu_op    = out_q[EW-1 -: OP_WIDTH];
  assign alu_a     = out_q[2*DATA_WIDTH-1 -: DATA_WIDTH];
  assign alu_b     = out_q[DATA_WIDTH-1:0];
  assign alu_ch_id = ch_id_q;

`ifdef ALU_IN_ARB_STATS_EN
  logic [15:0] gcnt_q [NUM_CH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) gcnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (pop[i] && (gcnt_q[i] != 16'hFFFF)) gcnt_q[i] <= gcnt_q[i] + 16'd1;
      end
    end
  end

  always_comb begin
    grant_count = '0;
    for (int i = 0; i < NUM_CH; i++) grant_count[i*16 +: 16] = gcnt_q[i];
  end
`endif

endmodule

// File: tb/tb_alu_in_cmd_arbiter.sv
// tb/tb_alu_in_cmd_arbiter.sv - scoreboard bench for round-robin and fixed-priority arbiter instances
// Exercises grant_count as well when ALU_IN_ARB_STATS_EN is defined.
module tb_alu_in_cmd_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  v0, v1, r0, r1, e0, e1;
  logic [11:0] op0, op1;
  logic [31:0] a0, b0, a1, b1;
  logic        rdy0, rdy1, av0, av1;
  logic [2:0]  aop0, aop1;
  logic [7:0]  aa0, ab0, aa1, ab1;
  logic [1:0]  aid0, aid1;
`ifdef ALU_IN_ARB_STATS_EN
  logic [63:0] gc0, gc1;
`endif

  logic [20:0] q0[$];
  logic [20:0] q1[$];
  int n_checks = 0;
  int n_pass   = 0;

  alu_in_cmd_arbiter #(.ARB_MODE(0)) dut0 (
    .clk(clk), .rst(rst_n), .ch_valid(v0), .ch_ready(r0), .ch_op(op0),
    .ch_a(a0), .ch_b(b0), .alu_valid(av0), .alu_ready(rdy0), .alu_op(aop0),
    .alu_a(aa0), .alu_b(ab0), .alu_ch_id(aid0), .ch_empty(e0)
`ifdef ALU_IN_ARB_STATS_EN
    , .grant_count(gc0)
`endif
  );

  alu_in_cmd_arbiter #(.ARB_MODE(1)) dut1 (
    .clk(clk), .rst(rst_n), .ch_valid(v1), .ch_ready(r1), .ch_op(op1),
    .ch_a(a1), .ch_b(b1), .alu_valid(av1), .alu_ready(rdy1), .alu_op(aop1),
    .alu_a(aa1), .alu_b(ab1), .alu_ch_id(aid1), .ch_empty(e1)
`ifdef ALU_IN_ARB_STATS_EN
    , .grant_count(gc1)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [20:0] ent(input int ch, input int op, input int a, input int b);
    return {2'(ch), 3'(op), 8'(a), 8'(b)};
  endfunction

  // Monitors: every accepted ALU command must match the head of its expected queue
  always @(negedge clk) begin
    if (rst_n && av0 && rdy0) begin
      if (q0.size() == 0) begin
        n_checks++;
        $display("FAIL dut0_unexpected: got %0h expected none", {aid0, aop0, aa0, ab0});
      end else check("dut0_out", 64'({aid0, aop0, aa0, ab0}), 64'(q0.pop_front()));
    end
    if (rst_n && av1 && rdy1) begin
      if (q1.size() == 0) begin
        n_checks++;
        $display("FAIL dut1_unexpected: got %0h expected none", {aid1, aop1, aa1, ab1});
      end else check("dut1_out", 64'({aid1, aop1, aa1, ab1}), 64'(q1.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd0(input int ch, input int op, input int a, input int b);
    op0[ch*3 +: 3] = 3'(op);
    a0[ch*8 +: 8]  = 8'(a);
    b0[ch*8 +: 8]  = 8'(b);
  endtask

  task automatic set_cmd1(input int ch, input int op, input int a, input int b);
    op1[ch*3 +: 3] = 3'(op);
    a1[ch*8 +: 8]  = 8'(a);
    b1[ch*8 +: 8]  = 8'(b);
  endtask

  task automatic do_reset();
    v0 = '0; v1 = '0; rdy0 = 1'b0; rdy1 = 1'b1;
    rst_n = 1'b0;
    q0.delete(); q1.delete();
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic drain(input int which, input string name);
    int n = 0;
    while (((which == 0) ? q0.size() : q1.size()) != 0 && n < 60) begin
      tick();
      n++;
    end
    check(name, 64'((which == 0) ? q0.size() : q1.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int acc;
    logic [20:0] ch3_exp [4];
    v0 = '0; v1 = '0; op0 = '0; op1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    rdy0 = 1'b0; rdy1 = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_alu_valid", 64'(av0), 64'd0);
    check("rst_fields", 64'({aid0, aop0, aa0, ab0}), 64'd0);
    check("rst_ch_ready", 64'(r0), 64'hF);
    check("rst_ch_empty", 64'(e0), 64'hF);
    check("rst_dut1_valid_empty", 64'({av1, e1}), 64'h0F);
    tick();
    rst_n = 1'b1;

    // Single command on ch2: no bypass, valid one edge after the push edge
    rdy0 = 1'b1;
    set_cmd0(2, 1, 'h12, 'h34);
    v0 = 4'b0100;
    q0.push_back(ent(2, 1, 'h12, 'h34));
    tick();
    v0 = '0;
    check("lat_no_bypass", 64'(av0), 64'd0);
    check("lat_ch2_not_empty", 64'(e0[2]), 64'd0);
    tick();
    check("lat_valid", 64'(av0), 64'd1);
    drain(0, "single_drain");

    // Round robin from reset: grant order 0,1,2,3 back to back
    do_reset();
    rdy0 = 1'b1;
    for (int ch = 0; ch < 4; ch++) begin
      set_cmd0(ch, ch + 4, 'hA0 + ch, 'hB0 + ch);
      q0.push_back(ent(ch, ch + 4, 'hA0 + ch, 'hB0 + ch));
    end
    v0 = 4'hF;
    tick();
    v0 = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("b2b_valid", 64'(av0), 64'd1);
      check("rr_order", 64'(aid0), 64'(k));
    end
    drain(0, "rr_drain");
    tick();
    check("back_to_empty", 64'(av0), 64'd0);

    // Pointer after granting ch1 is 2, so ch3 wins over ch0
    set_cmd0(1, 2, 'h11, 'h22);
    q0.push_back(ent(1, 2, 'h11, 'h22));
    v0 = 4'b0010;
    tick();
    v0 = '0;
    tick();
    set_cmd0(0, 3, 'h01, 'h02);
    set_cmd0(3, 6, 'h31, 'h32);
    q0.push_back(ent(3, 6, 'h31, 'h32));
    q0.push_back(ent(0, 3, 'h01, 'h02));
    v0 = 4'b1001;
    tick();
    v0 = '0;
    drain(0, "rr_wrap_drain");

    // Stalled fill of ch0: output register plus four FIFO entries
    do_reset();
    acc = 0;
    v0 = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      set_cmd0(0, k, 'h40 + k, 'h50 + k);
      if (r0[0]) begin
        q0.push_back(ent(0, k, 'h40 + k, 'h50 + k));
        acc++;
      end
      tick();
    end
    v0 = '0;
    check("fill_accepted", 64'(acc), 64'd5);
    check("full_not_ready", 64'(r0), 64'hE);
    check("stall_valid", 64'(av0), 64'd1);
    check("stall_fields", 64'({aid0, aop0, aa0, ab0}), 64'(ent(0, 0, 'h40, 'h50)));
    tick(); tick(); tick();
    check("stall_stable", 64'({av0, aid0, aop0, aa0, ab0}), 64'({1'b1, ent(0, 0, 'h40, 'h50)}));
    rdy0 = 1'b1;
    drain(0, "fill_drain");
    check("ready_after_drain", 64'(r0), 64'hF);

    // Asynchronous reset mid-transfer clears everything before the next edge
    do_reset();
    for (int ch = 0; ch < 4; ch++) begin
      set_cmd0(ch, ch, 'h70 + ch, 'h80 + ch);
      q0.push_back(ent(ch, ch, 'h70 + ch, 'h80 + ch));
    end
    v0 = 4'hF;
    tick();
    v0 = '0;
    tick();
    check("pre_rst_valid", 64'({av0, e0}), 64'h11);
    #2 rst_n = 1'b0;
    q0.delete();
    #1;
    check("async_rst_valid", 64'(av0), 64'd0);
    check("async_rst_empty_ready", 64'({e0, r0}), 64'hFF);
    check("async_rst_fields", 64'({aid0, aop0, aa0, ab0}), 64'd0);
    tick();
    rst_n = 1'b1;
    rdy0 = 1'b1;
    repeat (5) tick();
    check("no_replay", 64'({av0, e0}), 64'h0F);

    // Fixed priority: ch3 waits until ch1 has drained
    rdy1 = 1'b1;
    v1 = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      set_cmd1(1, k, 'h10 + k, 'h20 + k);
      set_cmd1(3, 4 + k, 'h30 + k, 'h40 + k);
      q1.push_back(ent(1, k, 'h10 + k, 'h20 + k));
      ch3_exp[k] = ent(3, 4 + k, 'h30 + k, 'h40 + k);
      check("prio_ch3_ready", 64'(r1[3]), 64'd1);
      tick();
    end
    v1 = '0;
    for (int k = 0; k < 4; k++) q1.push_back(ch3_exp[k]);
    drain(1, "prio_drain");

`ifdef ALU_IN_ARB_STATS_EN
    do_reset();
    rdy0 = 1'b1;
    v0 = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      set_cmd0(1, k, 'h60 + k, 'h70 + k);
      q0.push_back(ent(1, k, 'h60 + k, 'h70 + k));
      tick();
    end
    v0 = '0;
    drain(0, "stats_drain");
    tick();
    check("stats_ch1", 64'(gc0[31:16]), 64'd5);
    check("stats_others", 64'({gc0[63:32], gc0[15:0]}), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
